// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64 pipeline widths, opcodes, ALUOp encodings and control bundle
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int RA_W = 5;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BCMP  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-side inputs, EX-side registered outputs and stall of the ID/EX register
interface id_ex_stage_reg_if;
  import riscv_pkg::*;
  logic            id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]      id_alu_op;
  logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic            flush;
  logic            ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]      ex_alu_op;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic            ex_valid;
  logic            stall;
  modport master (
    output id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write,
           id_alu_op, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct, flush,
    input  ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid, stall
  );
  modport slave (
    input  id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write,
           id_alu_op, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct, flush,
    output ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid, stall
  );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// load_use_detect: flags a decode-stage read of the register a load in EX is still fetching
module load_use_detect
  import riscv_pkg::*;
(
  input  logic            ex_mem_read_i,
  input  logic            ex_valid_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  output logic            stall_o
);
  // rs2 is compared even for opcodes that ignore it; the extra stall is harmless
  assign stall_o = ex_mem_read_i & ex_valid_i & (ex_rd_i != '0) &
                   ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush and bubble insertion
// Load-use stall detection is built only when HAZARD_DETECT_EN is defined; otherwise stall is 0.
module id_ex_stage_reg
  import riscv_pkg::*;
(
  input logic         clk,
  input logic         reset,
  id_ex_stage_reg_if.slave bus
);
  ctrl_t           ctrl_q, ctrl_d, ctrl_in;
  logic            valid_q, valid_d, bubble, stall;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]      funct_q;
`ifdef HAZARD_DETECT_EN
  load_use_detect u_lud (
    .ex_mem_read_i(ctrl_q.mem_read),
    .ex_valid_i   (valid_q),
    .ex_rd_i      (rd_q),
    .id_rs1_i     (bus.id_rs1),
    .id_rs2_i     (bus.id_rs2),
    .stall_o      (stall)
  );
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    ctrl_in = '{alu_op: bus.id_alu_op, branch: bus.id_branch, mem_read: bus.id_mem_read,
                mem_to_reg: bus.id_mem_to_reg, mem_write: bus.id_mem_write,
                alu_src: bus.id_alu_src, reg_write: bus.id_reg_write};
    bubble  = bus.flush | stall;
    ctrl_d  = bubble ? CTRL_BUBBLE : ctrl_in;
    valid_d = ~bubble;
  end
  // data fields load every cycle; a bubble's zero control makes them inert
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      funct_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc_q    <= bus.id_pc;
      rd1_q   <= bus.id_rd1;
      rd2_q   <= bus.id_rd2;
      imm_q   <= bus.id_imm;
      rs1_q   <= bus.id_rs1;
      rs2_q   <= bus.id_rs2;
      rd_q    <= bus.id_rd;
      funct_q <= bus.id_funct;
    end
  end
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd1        = rd1_q;
  assign bus.ex_rd2        = rd2_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rs1        = rs1_q;
  assign bus.ex_rs2        = rs2_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_funct      = funct_q;
  assign bus.ex_valid      = valid_q;
  assign bus.stall         = stall;
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the 5-stage RV64 pipeline. It captures the decode-stage control bundle (ALUOp, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite), together with operands and register addresses, and presents them to EX one cycle later. It holds the load-use hazard detector: on a load-use hazard it stalls PC and IF/ID and inserts a bubble. It also accepts a flush from the branch-resolution stage.

## Interface
- XLEN, 64, datapath width
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoded control
- id_alu_op  in  2  decoded ALUOp (00 add, 01 branch compare, 10 funct-decoded)
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  PC, register-file read data, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
- id_funct  in  4  {instr[30], instr[14:12]}
- flush  in  1  branch taken in EX/MEM; kill the instruction entering EX
- ex_* (same names, ex_ prefix)  out  same widths  registered copies of every id_* input
- ex_valid  out  1  EX holds a real instruction, not a bubble
- stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- Each rising clk has one outcome, chosen in this priority order:
  1. **reset:** every ex_* output and ex_valid go to 0.
  2. **flush:** all control outputs go to 0 and ex_valid goes to 0. Data fields may load or hold; their values do not matter.
  3. **stall:** load a bubble. Control outputs go to 0 and ex_valid goes to 0. Data fields load normally; they are harmless because the control is zero.
  4. **normal:** load every id_* input and set ex_valid to 1.
- **stall condition:** ex_mem_read & ex_valid & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - rs2 is compared for every opcode. This is a conservative stall, accepted.
- stall is purely combinational from registered ex_* state and the id_* inputs. It has no dependence on flush.
  - The upstream PC/IF-ID logic gives flush priority over stall.
- A bubble clears ex_mem_read, so stall never lasts more than one consecutive cycle for a single load.
- Control outputs are never X after reset. The x on MemtoReg for store and branch is resolved to 0 upstream; this block passes 0/1 values only.

## Timing
- **Latency:** id_* sampled at edge N appear on ex_* after edge N.
- **Reset:** all outputs are 0 in the cycle after reset is sampled high. stall is 0 while ex_valid = 0.
- **Reset mid-stall:** reset wins. stall deasserts in the cycle after reset because ex_valid = 0.
- **Flush and stall in the same cycle:** result is a bubble either way; ex_valid = 0.
- **Back-to-back loads:** the second load can itself stall its consumer. Each stall is independent.
- **x0 as destination:** never stalls.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection as above.
- HAZARD_DETECT_EN undefined:
  - stall is tied to 0 and the stall/bubble path is removed.
  - Software must schedule a NOP after each load.
  - Flush and reset behaviour is unchanged.

## Structure
- Shared package riscv_pkg holds:
  - the opcode constants (R-type 0110011, load 0000011, store 0100011, OP-IMM 0010011, branch 1100011)
  - the ALUOp encodings
  - a packed ctrl_t struct of the eight control bits, with a CTRL_BUBBLE constant of all zeros
- Sub-module load_use_detect: combinational hazard compare, producing stall. Instantiated only under HAZARD_DETECT_EN.

## Test plan
- **Reset:** assert reset 2 cycles with non-zero id_* inputs → all ex_* = 0, ex_valid = 0, stall = 0.
- **Normal pass:** id_reg_write = 1, id_alu_op = 10, id_rd = 5, id_rd1 = 0x10 → next cycle ex_reg_write = 1, ex_alu_op = 10, ex_rd = 5, ex_rd1 = 0x10, ex_valid = 1.
- **Load-use:** `ld x6` in EX (ex_mem_read = 1, ex_rd = 6), then `add` with id_rs2 = 6:
  - same cycle: stall = 1
  - next cycle: ex_valid = 0, all control = 0, stall = 0
- **x0 / no-match:** ex_mem_read = 1 with ex_rd = 0, or with ex_rd = 7 and id_rs1 = id_rs2 = 3 → stall = 0.
- **Flush:** flush = 1 with id_mem_write = 1 → next cycle ex_mem_write = 0, ex_valid = 0. Repeat with flush and a load-use stall together → bubble, ex_valid = 0.
- **Build without HAZARD_DETECT_EN:** repeat the load-use scenario → stall = 0, and the add enters EX with ex_valid = 1.
